telem_frame_buffer: RTL and testbench

// - Parametrised telemetry register bank: NCH channels (coordinates, time) of W bits, written by channel address.
// - On a snapshot strobe, copies every channel atomically into a shadow frame.
// - Streams the frame one channel per beat over a valid/ready interface to the downlink/display stage.
// - Replaces the fixed 8-bit per-coordinate flop groups and the 5-to-32 target decode.

---
 rtl/telem_frame_buffer.sv | 127 ++++++++++++
 tb/tb_telem_frame_buffer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/telem_frame_buffer.sv
// Telemetry register bank with atomic snapshot and valid/ready frame streaming.
// Optional checksum beat enabled by defining TELEM_CHECKSUM_EN.
module telem_frame_buffer #(
  parameter int W   = 8,
  parameter int NCH = 4,
  parameter int AW  = 2,
  parameter int FCW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic           clr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [W-1:0]   wr_data,
  input  logic           snap,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [AW:0]    out_chan,
  output logic           out_last,
  output logic           busy,
  output logic [FCW-1:0] frame_cnt,
  output logic           snap_drop,
  output logic           addr_err
);

`ifdef TELEM_CHECKSUM_EN
  localparam int NB = NCH + 1;
`else
  localparam int NB = NCH;
`endif
  localparam logic [AW:0] LAST_IDX = (AW+1)'(NB - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    live   [NCH];
  logic [W-1:0]    shadow [NCH];
  logic [AW:0]     idx;
  logic            xfer;
  logic            wr_any;
  logic            addr_ok;
  logic            start;

  assign wr_any  = wr_en | clr_en;
  assign addr_ok = ({1'b0, wr_addr} < (AW+1)'(NCH));
  assign xfer    = out_valid & out_ready;
  assign start   = (state == IDLE) & snap;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (snap) state_nxt = SEND;
      SEND:    if (xfer && idx == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the banks are small flop arrays that must read as zero after reset, so they are reset like any other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) live[i] <= '0;
    end else if (wr_any && addr_ok) begin
      for (int i = 0; i < NCH; i++)
        if (wr_addr == AW'(i)) live[i] <= clr_en ? '0 : wr_data;
    end
  end

`ifdef TELEM_CHECKSUM_EN
  logic [W-1:0] live_sum;
  logic [W-1:0] chk;

  always_comb begin
    live_sum = '0;
    for (int i = 0; i < NCH; i++) live_sum = live_sum + live[i];
  end

  always_ff @(posedge clk) begin
    if (rst)        chk <= '0;
    else if (start) chk <= live_sum;
  end
`endif

  // Shadow copy takes the live values as they stood before any same-cycle write.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) shadow[i] <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      snap_drop <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      snap_drop <= snap & (state == SEND);
      addr_err  <= wr_any & ~addr_ok;
      if (start) begin
        for (int i = 0; i < NCH; i++) shadow[i] <= live[i];
        idx       <= '0;
        frame_cnt <= frame_cnt + 1'b1;
      end else if (xfer) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    end
  end

  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign out_chan  = busy ? idx : '0;
  assign out_last  = busy & (idx == LAST_IDX);

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NCH; i++)
      if (idx == (AW+1)'(i)) out_data = shadow[i];
`ifdef TELEM_CHECKSUM_EN
    if (idx == (AW+1)'(NCH)) out_data = chk;
`endif
    if (!busy) out_data = '0;
  end

endmodule

// File: tb/tb_telem_frame_buffer.sv
// Directed self-checking bench for telem_frame_buffer (W=8, NCH=4, AW=3 so wr_addr=4 is reachable).
module tb_telem_frame_buffer;
  localparam int W = 8, NCH = 4, AW = 3, FCW = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           wr_en = 1'b0, clr_en = 1'b0, snap = 1'b0, out_ready = 1'b0;
  logic [AW-1:0]  wr_addr = '0;
  logic [W-1:0]   wr_data = '0;
  logic           out_valid, out_last, busy, snap_drop, addr_err;
  logic [W-1:0]   out_data;
  logic [AW:0]    out_chan;
  logic [FCW-1:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  logic [FCW-1:0] exp_cnt = '0;

  telem_frame_buffer #(.W(W), .NCH(NCH), .AW(AW), .FCW(FCW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .clr_en(clr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .snap(snap), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chan(out_chan), .out_last(out_last), .busy(busy),
    .frame_cnt(frame_cnt), .snap_drop(snap_drop), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Expects beat 0 already visible; exp packs {ch3,ch2,ch1,ch0}. out_ready must be 1.
  task automatic run_frame(input string tag, input logic [31:0] exp, input bit snap_last);
    logic [W-1:0] sum;
    logic [W-1:0] d;
    bit           last_expected;
    sum = '0;
    for (int b = 0; b < NCH; b++) begin
      d = exp[8*b +: 8];
      sum = sum + d;
`ifdef TELEM_CHECKSUM_EN
      last_expected = 1'b0;
`else
      last_expected = (b == NCH - 1);
`endif
      check({tag, " valid"}, 32'(out_valid), 32'd1);
      check({tag, " data"},  32'(out_data),  32'(d));
      check({tag, " chan"},  32'(out_chan),  32'(b));
      check({tag, " last"},  32'(out_last),  32'(last_expected));
      if (b == NCH - 1 && snap_last) snap = 1'b1;
      step();
      snap = 1'b0;
    end
`ifdef TELEM_CHECKSUM_EN
    check({tag, " csum valid"}, 32'(out_valid), 32'd1);
    check({tag, " csum chan"},  32'(out_chan),  32'(NCH));
    check({tag, " csum data"},  32'(out_data),  32'(sum));
    check({tag, " csum last"},  32'(out_last),  32'd1);
    step();
`endif
    check({tag, " end valid"}, 32'(out_valid), 32'd0);
    check({tag, " end busy"},  32'(busy),      32'd0);
  endtask

  task automatic start_snap();
    snap = 1'b1;
    step();
    snap = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
  endtask

  initial begin
    int budget;
    // Reset dominates snap and write.
    step();
    rst = 1'b1; snap = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 8'hAA;
    step();
    rst = 1'b0; snap = 1'b0; wr_en = 1'b0;
    check("rst valid", 32'(out_valid), 32'd0);
    check("rst busy",  32'(busy),      32'd0);
    check("rst data",  32'(out_data),  32'd0);
    check("rst chan",  32'(out_chan),  32'd0);
    check("rst last",  32'(out_last),  32'd0);
    check("rst cnt",   32'(frame_cnt), 32'd0);
    check("rst drop",  32'(snap_drop), 32'd0);
    check("rst aerr",  32'(addr_err),  32'd0);
    out_ready = 1'b1;
    start_snap();
    run_frame("zero", 32'h0000_0000, 1'b0);
    check("zero cnt", 32'(frame_cnt), 32'(exp_cnt));

    // Plain write then stream.
    write(0, 8'h11); write(1, 8'h22); write(2, 8'h33); write(3, 8'h44);
    start_snap();
    run_frame("basic", 32'h4433_2211, 1'b0);
    check("basic cnt", 32'(frame_cnt), 32'(exp_cnt));

    // Backpressure at beat 1 with a live write and a dropped snap underneath.
    start_snap();
    check("bp b0", 32'(out_data), 32'h11);
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("bp valid", 32'(out_valid), 32'd1);
      check("bp data",  32'(out_data),  32'h22);
      check("bp chan",  32'(out_chan),  32'd1);
      if (k == 2) check("bp drop", 32'(snap_drop), 32'd1);
      if (k == 0) begin wr_en = 1'b1; wr_addr = 1; wr_data = 8'h99; end
      if (k == 1) snap = 1'b1;
      step();
      wr_en = 1'b0; snap = 1'b0;
    end
    check("bp drop end", 32'(snap_drop), 32'd0);
    check("bp cnt", 32'(frame_cnt), 32'(exp_cnt));
    out_ready = 1'b1;
    check("bp b1", 32'(out_data), 32'h22);
    step();
    check("bp b2", 32'(out_data), 32'h33);
    step();
    check("bp b3", 32'(out_data), 32'h44);
    check("bp b3 last", 32'(out_last), 32'd1);
    step();
    check("bp idle", 32'(busy), 32'd0);

    // clr_en beats wr_en; out-of-range address flags and changes nothing.
    wr_en = 1'b1; clr_en = 1'b1; wr_addr = 2; wr_data = 8'h66;
    step();
    clr_en = 1'b0; wr_addr = 4; wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    check("aerr pulse", 32'(addr_err), 32'd1);
    step();
    check("aerr clear", 32'(addr_err), 32'd0);
    start_snap();
    run_frame("clr", 32'h4400_9911, 1'b0);

    // Snap with same-cycle write of ch0, plus snap on the last beat.
    wr_en = 1'b1; wr_addr = 0; wr_data = 8'h55;
    start_snap();
    wr_en = 1'b0;
    run_frame("coll", 32'h4400_9911, 1'b1);
    check("last drop", 32'(snap_drop), 32'd1);
    check("last cnt",  32'(frame_cnt), 32'(exp_cnt));

    // Keep snapping until the counter wraps.
    while (exp_cnt != '0) begin
      start_snap();
      budget = 0;
      while (busy && budget < 20) begin step(); budget++; end
      if (busy) check("wrap timeout", 32'(busy), 32'd0);
    end
    check("wrap cnt", 32'(frame_cnt), 32'd0);

    // Reset while beat 2 is on the bus.
    start_snap();
    step(); step();
    check("mid b2", 32'(out_chan), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid valid", 32'(out_valid), 32'd0);
    check("mid cnt",   32'(frame_cnt), 32'd0);
    exp_cnt = '0;
    start_snap();
    run_frame("mid fresh", 32'h0000_0000, 1'b0);

    // Checksum wraps mod 256 when enabled; plain 4-beat frame otherwise.
    write(0, 8'hFF); write(1, 8'h01); write(2, 8'h10); write(3, 8'h20);
    start_snap();
    run_frame("csum", 32'h2010_01FF, 1'b0);
    check("csum cnt", 32'(frame_cnt), 32'(exp_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
